program_loader: RTL and testbench
=================================

# program_loader

Writes instructions into instruction memory. It accepts decoded instruction fields (opcode, register address, stack register address, immediate, branch address) over a valid/ready handshake. It packs each set into the 16-bit instruction word format that the instruction register splits apart, then writes the words to consecutive instruction-memory addresses. It sits between the host/test front end and instruction memory, ahead of the fetch path.

## Interface
- `DEPTH`, default 1024: number of instruction-memory words; the last writable address is DEPTH-1.
- `ADDR_W`, default 10: memory address width; DEPTH ≤ 2^ADDR_W.
- `BASE_ADDR`, default 0: first address written after START.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `START` in 1: one-cycle pulse that begins a load; ignored unless in IDLE.
- `IN_VALID` in 1: field set is valid.
- `IN_READY` out 1: loader accepts a field set this cycle.
- `FMT` in 2: word format; 0 = reg/imm, 1 = stack, 2 = branch, 3 = opcode-only.
- `OPCODE` in 6: goes to word[15:10].
- `REGISTER_ADDRESS` in 1: used when FMT=0.
- `REGISTER_ADDRESS_STACK` in 2: used when FMT=1.
- `IMMEDIATE` in 9: used when FMT=0 or 1.
- `BA` in 10: branch address, used when FMT=2.
- `LAST` in 1: qualifies the final field set of the load.
- `MEM_WE` out 1: memory write strobe.
- `MEM_ADDR` out ADDR_W: write address.
- `MEM_DATA` out 16: packed instruction word.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse when a load ends.
- `FULL` out 1: sticky; set when the write at DEPTH-1 occurs, cleared by START.
- `COUNT` out ADDR_W+1: words written since START.
- `ERR` out 1: sticky range-error flag; present only with the macro.

## Operation
- Packing:
  - FMT0 → {OPCODE, REGISTER_ADDRESS, IMMEDIATE[8:0]}
  - FMT1 → {OPCODE, REGISTER_ADDRESS_STACK, IMMEDIATE[7:0]}
  - FMT2 → {OPCODE, BA}
  - FMT3 → {OPCODE, 10'd0}
- States are IDLE, LOAD, WRITE and FINISH.
- IDLE:
  - IN_READY=0.
  - START loads ptr=BASE_ADDR, COUNT=0, FULL=0 (and ERR=0), then goes to LOAD.
- LOAD:
  - IN_READY=1.
  - On IN_VALID&IN_READY, MEM_DATA and MEM_ADDR=ptr are registered, the LAST flag is latched, and the state goes to WRITE.
- WRITE:
  - MEM_WE=1 for exactly one cycle.
  - ptr and COUNT increment.
  - If ptr==DEPTH-1, FULL is set and the state goes to FINISH.
  - Otherwise, if latched LAST=1, the state goes to FINISH.
  - Otherwise it returns to LOAD.
- FINISH: DONE=1 for one cycle, then IDLE.
- START outside IDLE is ignored. IN_VALID outside LOAD is ignored; the producer holds it.
- Unused input fields are don't-care and never affect MEM_DATA.
- Reset mid-operation: every output goes to 0 and the state goes to IDLE. A pending word is discarded and is not written.
- Reset values: IN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, BUSY=0, DONE=0, FULL=0, COUNT=0, ERR=0.

## Timing
- Handshake at edge k → MEM_WE high in cycle k+1 with stable MEM_ADDR/MEM_DATA. Memory samples at edge k+2.
- IN_READY is low during WRITE, so sustained throughput is 1 word / 2 cycles.
- DONE is high in the cycle after the final WRITE cycle. BUSY falls in the same cycle DONE falls.
- All outputs are registered; there is no combinational input→output path.
- START-to-IN_READY latency is 1 cycle.

## Configuration
- `PROGRAM_LOADER_RANGE_CHECK_EN` defined:
  - A FMT1 handshake with IMMEDIATE[8]=1 is consumed without a write.
  - ERR is set and stays set until START or RST; the state stays LOAD.
  - If that set had LAST=1, the state goes to FINISH.
- Not defined: there is no ERR port, and IMMEDIATE[8] is silently truncated for FMT1.

## Structure
- Shared package `isa_pkg` holds:
  - the FMT encodings;
  - field positions: OPC[15:10], RA[9], RAS[9:8], IMM[8:0], BA[9:0];
  - the loader state enum.
- The instruction register uses the same field constants.
- Sub-module `instruction_packer`: combinational, takes FMT plus the fields and produces the 16-bit word. Its test runs separately.

## Test plan
- Format checks, each a single field set with LAST=1:
  - FMT0, OPCODE=6'h05, REGISTER_ADDRESS=1, IMMEDIATE=9'h1A3 → one write, MEM_ADDR=0, MEM_DATA=16'h17A3, DONE pulse, COUNT=1.
  - FMT1, OPCODE=6'h02, REGISTER_ADDRESS_STACK=2'b11, IMMEDIATE=9'h05A → MEM_DATA=16'h0B5A.
  - FMT2, OPCODE=6'h3F, BA=10'h2AB → 16'hFEAB.
  - FMT3, OPCODE=6'h01 → 16'h0400.
- BASE_ADDR=8: stream 3 sets with IN_VALID held high, LAST on the third → writes at 8, 9, 10 on alternating cycles, IN_READY low every WRITE cycle, COUNT=3.
- DEPTH=4: stream 5 sets with no LAST → writes at addresses 0–3, FULL=1, DONE pulse, the fifth set is never accepted, IN_READY=0.
- Assert RST during WRITE of word 2 → MEM_WE drops immediately, all outputs 0, IDLE. A new START restarts at BASE_ADDR.
- With the macro: FMT1 with IMMEDIATE=9'h100 → no MEM_WE, ERR=1. The next FMT0 set is written at the same address.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: instruction-word formats, field positions and the loader state
// encoding shared by the program loader, its packer and the instruction register.
package isa_pkg;

  localparam int INSTR_W = 16;

  // Word field positions (the instruction register slices the same bits)
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int RA_BIT  = 9;
  localparam int RAS_MSB = 9;
  localparam int RAS_LSB = 8;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int BA_MSB  = 9;
  localparam int BA_LSB  = 0;

  // Word formats as carried on the FMT input
  typedef enum logic [1:0] {
    FMT_REG_IMM = 2'd0,
    FMT_STACK   = 2'd1,
    FMT_BRANCH  = 2'd2,
    FMT_OPC     = 2'd3
  } fmt_e;

  // Program loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instruction_packer.sv
// instruction_packer: combinational packing of decoded fields into one
// 16-bit instruction word. Fields not used by the selected format never
// reach the word.
module instruction_packer
  import isa_pkg::*;
(
  input  logic [1:0]         FMT,
  input  logic [5:0]         OPCODE,
  input  logic               REGISTER_ADDRESS,
  input  logic [1:0]         REGISTER_ADDRESS_STACK,
  input  logic [8:0]         IMMEDIATE,
  input  logic [9:0]         BA,
  output logic [INSTR_W-1:0] WORD
);

  // Select the field layout for the requested format
  always_comb begin
    WORD = '0;
    WORD[OPC_MSB:OPC_LSB] = OPCODE;
    case (FMT)
      FMT_REG_IMM: begin
        WORD[RA_BIT]          = REGISTER_ADDRESS;
        WORD[IMM_MSB:IMM_LSB] = IMMEDIATE;
      end
      FMT_STACK: begin
        // Stack form has only an 8-bit immediate; bit 8 is dropped here
        WORD[RAS_MSB:RAS_LSB]   = REGISTER_ADDRESS_STACK;
        WORD[IMM_MSB-1:IMM_LSB] = IMMEDIATE[7:0];
      end
      FMT_BRANCH: begin
        WORD[BA_MSB:BA_LSB] = BA;
      end
      default: begin
        WORD[BA_MSB:BA_LSB] = '0;
      end
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: accepts decoded field sets over valid/ready, packs each into
// an instruction word and writes it to consecutive instruction-memory
// addresses starting at BASE_ADDR.
// Optional feature macro: PROGRAM_LOADER_RANGE_CHECK_EN (adds ERR port and
// rejects stack-format sets whose immediate does not fit in 8 bits).
module program_loader
  import isa_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [1:0]        FMT,
  input  logic [5:0]        OPCODE,
  input  logic              REGISTER_ADDRESS,
  input  logic [1:0]        REGISTER_ADDRESS_STACK,
  input  logic [8:0]        IMMEDIATE,
  input  logic [9:0]        BA,
  input  logic              LAST,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              FULL,
  output logic [ADDR_W:0]   COUNT
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
  , output logic            ERR
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);

  ld_state_e           state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg;
  logic                last_reg;
  logic [15:0]         packed_word;
  logic                handshake;
  logic                range_err;

  instruction_packer u_packer (
    .FMT                    (FMT),
    .OPCODE                 (OPCODE),
    .REGISTER_ADDRESS       (REGISTER_ADDRESS),
    .REGISTER_ADDRESS_STACK (REGISTER_ADDRESS_STACK),
    .IMMEDIATE              (IMMEDIATE),
    .BA                     (BA),
    .WORD                   (packed_word)
  );

  assign handshake = (state_reg == ST_LOAD) && IN_VALID;

`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
  assign range_err = handshake && (FMT == FMT_STACK) && IMMEDIATE[8];
`else
  assign range_err = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (START) state_next = ST_LOAD;
      ST_LOAD: begin
        if (range_err)      state_next = LAST ? ST_FINISH : ST_LOAD;
        else if (handshake) state_next = ST_WRITE;
      end
      ST_WRITE:  state_next = (ptr_reg == LAST_ADDR || last_reg) ? ST_FINISH : ST_LOAD;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Status and strobe outputs decoded from the registered state only
  always_comb begin
    IN_READY = (state_reg == ST_LOAD);
    MEM_WE   = (state_reg == ST_WRITE);
    BUSY     = (state_reg != ST_IDLE);
    DONE     = (state_reg == ST_FINISH);
  end

  // Pointer, captured word, counters and sticky flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_reg  <= '0;
      last_reg <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      FULL     <= 1'b0;
      COUNT    <= '0;
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
      ERR      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            ptr_reg <= START_ADDR;
            COUNT   <= '0;
            FULL    <= 1'b0;
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
            ERR     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (handshake && !range_err) begin
            MEM_ADDR <= ptr_reg;
            MEM_DATA <= packed_word;
            last_reg <= LAST;
          end
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
          if (range_err) ERR <= 1'b1;
`endif
        end
        ST_WRITE: begin
          ptr_reg <= ptr_reg + 1'b1;
          COUNT   <= COUNT + 1'b1;
          if (ptr_reg == LAST_ADDR) FULL <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven format checks plus hand-written sequences
// for base address, depth limit, mid-write reset and (with the macro) the
// range-error path. Three loader instances share the field inputs; each has
// its own START so only the targeted instance runs.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1, start2;
  logic        in_valid;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic        ra;
  logic [1:0]  ras;
  logic [8:0]  imm;
  logic [9:0]  ba;
  logic        last;

  logic        rdy0, we0, busy0, done0, full0;
  logic [9:0]  addr0;
  logic [15:0] data0;
  logic [10:0] count0;
  logic        rdy1, we1, busy1, done1, full1;
  logic [9:0]  addr1;
  logic [15:0] data1;
  logic [10:0] count1;
  logic        rdy2, we2, busy2, done2, full2;
  logic [9:0]  addr2;
  logic [15:0] data2;
  logic [10:0] count2;
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
  logic        err0, err1, err2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  program_loader u0 (
    .CLK(clk), .RST(rst), .START(start0), .IN_VALID(in_valid), .IN_READY(rdy0),
    .FMT(fmt), .OPCODE(opcode), .REGISTER_ADDRESS(ra), .REGISTER_ADDRESS_STACK(ras),
    .IMMEDIATE(imm), .BA(ba), .LAST(last), .MEM_WE(we0), .MEM_ADDR(addr0),
    .MEM_DATA(data0), .BUSY(busy0), .DONE(done0), .FULL(full0), .COUNT(count0)
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    , .ERR(err0)
`endif
  );

  program_loader #(.BASE_ADDR(8)) u1 (
    .CLK(clk), .RST(rst), .START(start1), .IN_VALID(in_valid), .IN_READY(rdy1),
    .FMT(fmt), .OPCODE(opcode), .REGISTER_ADDRESS(ra), .REGISTER_ADDRESS_STACK(ras),
    .IMMEDIATE(imm), .BA(ba), .LAST(last), .MEM_WE(we1), .MEM_ADDR(addr1),
    .MEM_DATA(data1), .BUSY(busy1), .DONE(done1), .FULL(full1), .COUNT(count1)
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    , .ERR(err1)
`endif
  );

  program_loader #(.DEPTH(4)) u2 (
    .CLK(clk), .RST(rst), .START(start2), .IN_VALID(in_valid), .IN_READY(rdy2),
    .FMT(fmt), .OPCODE(opcode), .REGISTER_ADDRESS(ra), .REGISTER_ADDRESS_STACK(ras),
    .IMMEDIATE(imm), .BA(ba), .LAST(last), .MEM_WE(we2), .MEM_ADDR(addr2),
    .MEM_DATA(data2), .BUSY(busy2), .DONE(done2), .FULL(full2), .COUNT(count2)
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    , .ERR(err2)
`endif
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  opc;
    logic        ra;
    logic [1:0]  ras;
    logic [8:0]  imm;
    logic [9:0]  ba;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   n_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [5:0] o, input logic r,
                            input logic [1:0] rs, input logic [8:0] im,
                            input logic [9:0] b, input logic l);
    fmt = f; opcode = o; ra = r; ras = rs; imm = im; ba = b; last = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start0 = 0; start1 = 0; start2 = 0;
    in_valid = 0;
    set_fields(2'd0, 6'd0, 1'b0, 2'd0, 9'd0, 10'd0, 1'b0);

    // Unused fields carry junk so they are shown not to leak into the word
    vecs[0] = '{2'd0, 6'h05, 1'b1, 2'b10, 9'h1A3, 10'h3FF, 16'h17A3};
    vecs[1] = '{2'd1, 6'h02, 1'b1, 2'b11, 9'h05A, 10'h155, 16'h0B5A};
    vecs[2] = '{2'd2, 6'h3F, 1'b1, 2'b11, 9'h1FF, 10'h2AB, 16'hFEAB};
    vecs[3] = '{2'd3, 6'h01, 1'b1, 2'b10, 9'h155, 10'h3FF, 16'h0400};
    vecs[4] = '{2'd1, 6'h02, 1'b0, 2'b01, 9'h15A, 10'h000, 16'h095A};
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    n_vec = 4;
`else
    n_vec = 5;
`endif

    // Reset values
    cyc(); cyc();
    chk("rst_ready", rdy0, 0);
    chk("rst_we",    we0, 0);
    chk("rst_addr",  addr0, 0);
    chk("rst_data",  data0, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_full",  full0, 0);
    chk("rst_count", count0, 0);
`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    chk("rst_err",   err0, 0);
`endif
    rst = 1'b0;
    cyc();

    // Format table: one set with LAST per load
    for (int i = 0; i < n_vec; i++) begin
      start0 = 1; cyc(); start0 = 0;
      chk("fmt_ready_after_start", rdy0, 1);
      chk("fmt_busy", busy0, 1);
      set_fields(vecs[i].fmt, vecs[i].opc, vecs[i].ra, vecs[i].ras, vecs[i].imm, vecs[i].ba, 1'b1);
      in_valid = 1;
      cyc();
      in_valid = 0;
      chk("fmt_we",    we0, 1);
      chk("fmt_ready_in_write", rdy0, 0);
      chk("fmt_addr",  addr0, 0);
      chk("fmt_data",  data0, vecs[i].exp);
      $display("vec %0d fmt=%0d addr=%0h data=%h", i, vecs[i].fmt, addr0, data0);
      cyc();
      chk("fmt_done",  done0, 1);
      chk("fmt_we_off", we0, 0);
      chk("fmt_count", count0, 1);
      cyc();
      chk("fmt_done_pulse", done0, 0);
      chk("fmt_busy_off", busy0, 0);
    end

    // BASE_ADDR=8: three sets streamed with IN_VALID held high
    start1 = 1; cyc(); start1 = 0;
    in_valid = 1;
    for (int j = 0; j < 3; j++) begin
      set_fields(2'd3, 6'(j + 1), 1'b0, 2'd0, 9'd0, 10'd0, j == 2);
      chk("base_ready_load", rdy1, 1);
      cyc();
      chk("base_we",    we1, 1);
      chk("base_ready_write", rdy1, 0);
      chk("base_addr",  addr1, 8 + j);
      chk("base_data",  data1, (j + 1) * 16'h0400);
      $display("base write %0d addr=%0d data=%h", j, addr1, data1);
      if (j < 2) begin
        cyc();
        chk("base_we_gap", we1, 0);
      end
    end
    in_valid = 0;
    cyc();
    chk("base_done",  done1, 1);
    chk("base_count", count1, 3);
    chk("base_full",  full1, 0);
    cyc();
    chk("base_idle",  busy1, 0);

    // DEPTH=4: five sets without LAST; only four are written
    start2 = 1; cyc(); start2 = 0;
    in_valid = 1;
    for (int j = 0; j < 4; j++) begin
      set_fields(2'd2, 6'h10, 1'b0, 2'd0, 9'd0, 10'(j), 1'b0);
      cyc();
      chk("depth_we",   we2, 1);
      chk("depth_addr", addr2, j);
      chk("depth_data", data2, 16'h4000 + j);
      $display("depth write %0d addr=%0d data=%h", j, addr2, data2);
      if (j == 3) set_fields(2'd2, 6'h10, 1'b0, 2'd0, 9'd0, 10'd4, 1'b0);
      cyc();
      if (j < 3) chk("depth_ready", rdy2, 1);
    end
    chk("depth_done",  done2, 1);
    chk("depth_full",  full2, 1);
    chk("depth_count", count2, 4);
    chk("depth_ready_finish", rdy2, 0);
    cyc();
    chk("depth_ready_idle", rdy2, 0);
    chk("depth_we_idle", we2, 0);
    chk("depth_busy_idle", busy2, 0);
    chk("depth_done_pulse", done2, 0);
    chk("depth_full_sticky", full2, 1);
    cyc();
    chk("depth_no_fifth", we2, 0);
    chk("depth_count_hold", count2, 4);
    in_valid = 0;

    // Reset asserted during the WRITE of word 2
    start1 = 1; cyc(); start1 = 0;
    in_valid = 1;
    set_fields(2'd3, 6'h07, 1'b0, 2'd0, 9'd0, 10'd0, 1'b0);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("rstw_we_before", we1, 1);
    chk("rstw_addr_before", addr1, 10);
    #1 rst = 1'b1;
    #1;
    chk("rstw_we",    we1, 0);
    chk("rstw_addr",  addr1, 0);
    chk("rstw_data",  data1, 0);
    chk("rstw_count", count1, 0);
    chk("rstw_busy",  busy1, 0);
    chk("rstw_ready", rdy1, 0);
    chk("rstw_done",  done1, 0);
    chk("rstw_full",  full1, 0);
    in_valid = 0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rstw_no_write", we1, 0);
    start1 = 1; cyc(); start1 = 0;
    set_fields(2'd3, 6'h09, 1'b0, 2'd0, 9'd0, 10'd0, 1'b1);
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("restart_we",   we1, 1);
    chk("restart_addr", addr1, 8);
    chk("restart_data", data1, 16'h2400);
    cyc();
    chk("restart_done",  done1, 1);
    chk("restart_count", count1, 1);
    cyc();

`ifdef PROGRAM_LOADER_RANGE_CHECK_EN
    // Out-of-range stack immediate is consumed without a write
    start0 = 1; cyc(); start0 = 0;
    set_fields(2'd1, 6'h02, 1'b0, 2'b01, 9'h100, 10'd0, 1'b0);
    in_valid = 1;
    cyc();
    chk("err_no_we", we0, 0);
    chk("err_set",   err0, 1);
    chk("err_ready", rdy0, 1);
    set_fields(2'd0, 6'h05, 1'b1, 2'd0, 9'h1A3, 10'd0, 1'b1);
    cyc();
    in_valid = 0;
    chk("err_next_we",   we0, 1);
    chk("err_next_addr", addr0, 0);
    chk("err_next_data", data0, 16'h17A3);
    cyc();
    chk("err_done",   done0, 1);
    chk("err_sticky", err0, 1);
    chk("err_count",  count0, 1);
    cyc();
    start0 = 1; cyc(); start0 = 0;
    chk("err_cleared", err0, 0);
    set_fields(2'd3, 6'h01, 1'b0, 2'd0, 9'd0, 10'd0, 1'b1);
    in_valid = 1;
    cyc();
    in_valid = 0;
    cyc(); cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
